// File: rtl/fetch_pkg.sv
// Shared constants, queue entry type and width helper for the instruction fetch front end.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int unsigned PC_STEP   = 4;
  localparam int unsigned XLEN      = 64;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } fq_entry_t;

  // Bits needed to hold a count in the range 0..max_val inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch queue bus: redirect input, instruction memory request/response, pipeline handshake.
interface fetch_queue_if #(
  parameter int unsigned Nbits = 64
);
  logic             redirect_valid;
  logic [Nbits-1:0] redirect_pc;
  logic             imem_req;
  logic [Nbits-1:0] imem_addr;
  logic             imem_ready;
  logic             imem_rvalid;
  logic [31:0]      imem_rdata;
  logic             if_valid;
  logic [31:0]      if_instr;
  logic [Nbits-1:0] if_pc;
  logic             if_ready;

  modport master (
    input  redirect_valid, redirect_pc, imem_ready, imem_rvalid, imem_rdata, if_ready,
    output imem_req, imem_addr, if_valid, if_instr, if_pc
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_ready, imem_rvalid, imem_rdata, if_ready,
    input  imem_req, imem_addr, if_valid, if_instr, if_pc
  );
endinterface

// File: rtl/fq_fifo.sv
// Circular-buffer FIFO with simultaneous push/pop and synchronous clear.
module fq_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned Width = 96,
  parameter int unsigned Depth = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [Width-1:0]           wdata_i,
  output logic [Width-1:0]           rdata_o,
  output logic [cnt_width(Depth)-1:0] count_o,
  output logic                       empty_o
);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = cnt_width(Depth);

  logic [PtrW-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic             full, do_push, do_pop;

  assign full    = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[head_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full || do_pop);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    mem_d   = mem_q;
    if (clear_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) begin
        mem_d[tail_q] = wdata_i;
        tail_d        = tail_q + 1'b1;  // Depth is a power of two, so this wraps
      end
      if (do_pop) head_d = head_q + 1'b1;
      count_d = count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && !clear_i) assert (!(push_i && full && !pop_i));
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: credit-limited sequential fetch, in-order response queue,
// redirect flush with in-flight drop counting. Optional FETCHQ_BYPASS_EN: empty-queue bypass.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned      Nbits    = 64,
  parameter int unsigned      DEPTH    = 4,
  parameter int unsigned      MAX_OUT  = 2,
  parameter logic [Nbits-1:0] RESET_PC = '0
) (
  input logic          clk,
  input logic          rst,
  fetch_queue_if.master bus
);
  localparam int unsigned CntW = cnt_width(DEPTH);

  logic [Nbits-1:0]    fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d, redir_pc;
  logic [CntW-1:0]     out_q, out_d, drop_q, drop_d, fifo_count;
  logic [Nbits+31:0]   fifo_rdata;
  logic                fifo_empty, fifo_push, fifo_pop;
  logic                credit, accept, rsp_live, bypass;

  assign redir_pc = {bus.redirect_pc[Nbits-1:2], 2'b00};
  assign credit   = (({1'b0, fifo_count} + {1'b0, out_q}) < (CntW+1)'(DEPTH)) &&
                    (out_q < CntW'(MAX_OUT));
  // Gated by reset so no request is presented while the block is held in reset.
  assign bus.imem_req  = rst && credit && !bus.redirect_valid;
  assign bus.imem_addr = fetch_pc_q;
  assign accept        = bus.imem_req && bus.imem_ready;
  assign rsp_live      = bus.imem_rvalid && (drop_q == '0) && !bus.redirect_valid;

`ifdef FETCHQ_BYPASS_EN
  assign bypass = rsp_live && fifo_empty;
`else
  assign bypass = 1'b0;
`endif

  assign fifo_push = rsp_live && !(bypass && bus.if_ready);
  assign fifo_pop  = !fifo_empty && bus.if_ready;

  always_comb begin
    bus.if_valid = 1'b0;
    bus.if_instr = NOP_INSTR;
    bus.if_pc    = '0;
    if (bypass) begin
      bus.if_valid = 1'b1;
      bus.if_instr = bus.imem_rdata;
      bus.if_pc    = rsp_pc_q;
    end else if (!fifo_empty) begin
      bus.if_valid = 1'b1;
      bus.if_instr = fifo_rdata[31:0];
      bus.if_pc    = fifo_rdata[Nbits+31:32];
    end
  end

  always_comb begin
    fetch_pc_d = accept ? fetch_pc_q + Nbits'(PC_STEP) : fetch_pc_q;
    rsp_pc_d   = rsp_live ? rsp_pc_q + Nbits'(PC_STEP) : rsp_pc_q;
    out_d      = out_q + CntW'(accept) - CntW'(bus.imem_rvalid);
    drop_d     = drop_q;
    if (bus.imem_rvalid && (drop_q != '0)) drop_d = drop_q - CntW'(1);
    if (bus.redirect_valid) begin
      fetch_pc_d = redir_pc;
      rsp_pc_d   = redir_pc;
      drop_d     = out_d;  // everything still in flight after this cycle is stale
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      out_q      <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) assert (!(bus.imem_rvalid && (out_q == '0)));
  end

  fq_fifo #(
    .Width (Nbits + 32),
    .Depth (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clear_i (bus.redirect_valid),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i ({rsp_pc_q, bus.imem_rdata}),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

endmodule
